// File: rtl/alien_formation_tracker.sv
// Tracks the alien formation's top-left corner, edge limits and landing state.
// Optional step divider with speed-up on each DOWN step: define ALIEN_SPEEDUP_EN.
module alien_formation_tracker #(
  parameter int unsigned X_START     = 0,
  parameter int unsigned Y_START     = 32,
  parameter int unsigned X_STEP      = 8,
  parameter int unsigned Y_STEP      = 16,
  parameter int unsigned FORM_W      = 320,
  parameter int unsigned FORM_H      = 128,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned Y_LIMIT     = 448,
  parameter int unsigned SPEED_START = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] motion,
  output logic       canLeft,
  output logic       canRight,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic       moved,
  output logic       landed
);

  typedef enum logic [0:0] {StActive, StLanded} state_e;

  localparam logic [9:0]  XStep10  = 10'(X_STEP);
  localparam logic [10:0] XStep11  = 11'(X_STEP);
  localparam logic [10:0] FormW11  = 11'(FORM_W);
  localparam logic [10:0] ScreenW  = 11'(SCREEN_W);
  localparam logic [11:0] YStep12  = 12'(Y_STEP);
  localparam logic [11:0] FormH12  = 12'(FORM_H);
  localparam logic [11:0] YLimit12 = 12'(Y_LIMIT);

  localparam logic [2:0] MotLeft  = 3'd1;
  localparam logic [2:0] MotRight = 3'd2;
  localparam logic [2:0] MotDown  = 3'd3;

  state_e      state_q, state_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        moved_q, moved_d;
  logic        step;
  logic        down_taken;
  logic        can_left, can_right;
  logic [11:0] y_sum;

  assign can_left  = (pos_x_q >= XStep10) && (state_q == StActive);
  // 11-bit sum so a formation near the right edge cannot wrap into a false "fits"
  assign can_right = (({1'b0, pos_x_q} + FormW11 + XStep11) <= ScreenW) && (state_q == StActive);

`ifdef ALIEN_SPEEDUP_EN
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] ld_q, ld_d;

  // Divider only advances while active; a landed formation freezes it too
  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    step  = 1'b0;
    if (enable && (state_q == StActive)) begin
      if (cnt_q == 3'd0) begin
        step  = 1'b1;
        cnt_d = ld_q;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
    if (down_taken) begin
      ld_d  = (ld_q == 3'd0) ? 3'd0 : ld_q - 3'd1;
      cnt_d = ld_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 3'(SPEED_START);
      ld_q  <= 3'(SPEED_START);
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end
`else
  logic [2:0] unused_speed_start;
  assign unused_speed_start = 3'(SPEED_START);
  assign step = enable;
`endif

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    down_taken = 1'b0;
    y_sum      = {2'b00, pos_y_q} + YStep12;
    if ((state_q == StActive) && step) begin
      case (motion)
        MotLeft: begin
          if (can_left) pos_x_d = pos_x_q - XStep10;
        end
        MotRight: begin
          if (can_right) pos_x_d = pos_x_q + XStep10;
        end
        MotDown: begin
          down_taken = 1'b1;
          pos_y_d    = (y_sum > 12'd1023) ? 10'h3ff : y_sum[9:0];
          if (({2'b00, pos_y_d} + FormH12) >= YLimit12) state_d = StLanded;
        end
        default: ;
      endcase
    end
    moved_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StActive;
      pos_x_q <= 10'(X_START);
      pos_y_q <= 10'(Y_START);
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      moved_q <= moved_d;
    end
  end

  assign canLeft  = can_left;
  assign canRight = can_right;
  assign posX     = pos_x_q;
  assign posY     = pos_y_q;
  assign moved    = moved_q;
  assign landed   = (state_q == StLanded);

endmodule

// File: tb/tb_alien_formation_tracker.sv
// Scoreboard bench for alien_formation_tracker with default parameters.
// Define ALIEN_SPEEDUP_EN for both RTL and bench to exercise the divider.
module tb_alien_formation_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] motion;
  logic       canLeft, canRight, moved, landed;
  logic [9:0] posX, posY;

  alien_formation_tracker dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .motion   (motion),
    .canLeft  (canLeft),
    .canRight (canRight),
    .posX     (posX),
    .posY     (posY),
    .moved    (moved),
    .landed   (landed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       mv;
    logic       ld;
    logic       cl;
    logic       cr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int mx, my, mcnt, mld;
  bit mland;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 32; mland = 0; mcnt = 3; mld = 3;
  endtask

  function automatic exp_t model_exp(input bit mv);
    exp_t e;
    e.x  = 10'(mx);
    e.y  = 10'(my);
    e.mv = mv;
    e.ld = mland;
    e.cl = !mland && (mx >= 8);
    e.cr = !mland && (mx + 320 + 8 <= 640);
    return e;
  endfunction

  // One clock: drive at negedge, predict, then pop and compare after the edge
  task automatic drive(input bit en, input logic [2:0] mot);
    bit   stepc;
    int   ox, oy;
    exp_t e;
    @(negedge clk);
    enable = en;
    motion = mot;
    ox = mx; oy = my;
    stepc = en && !mland;
`ifdef ALIEN_SPEEDUP_EN
    if (stepc) begin
      if (mcnt != 0) begin
        mcnt--;
        stepc = 0;
      end else begin
        mcnt = mld;
      end
    end
`endif
    if (stepc) begin
      case (mot)
        3'd1: if (mx >= 8) mx -= 8;
        3'd2: if (mx + 328 <= 640) mx += 8;
        3'd3: begin
          my = (my + 16 > 1023) ? 1023 : my + 16;
          if (my + 128 >= 448) mland = 1;
`ifdef ALIEN_SPEEDUP_EN
          mld  = (mld > 0) ? mld - 1 : 0;
          mcnt = mld;
`endif
        end
        default: ;
      endcase
    end
    sb.push_back(model_exp((mx != ox) || (my != oy)));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("posX", 32'(posX), 32'(e.x));
    check_eq("posY", 32'(posY), 32'(e.y));
    check_eq("moved", 32'(moved), 32'(e.mv));
    check_eq("landed", 32'(landed), 32'(e.ld));
    check_eq("canLeft", 32'(canLeft), 32'(e.cl));
    check_eq("canRight", 32'(canRight), 32'(e.cr));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    motion = 3'd0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_posX"}, 32'(posX), 32'd0);
    check_eq({tag, "_posY"}, 32'(posY), 32'd32);
    check_eq({tag, "_canLeft"}, 32'(canLeft), 32'd0);
    check_eq({tag, "_canRight"}, 32'(canRight), 32'd1);
    check_eq({tag, "_moved"}, 32'(moved), 32'd0);
    check_eq({tag, "_landed"}, 32'(landed), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    motion = 3'd0;
    model_reset();
    #2;
    check_reset_outputs("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("after_reset");

`ifndef ALIEN_SPEEDUP_EN
    for (int i = 0; i < 40; i++) drive(1'b1, 3'd2);
    check_eq("right40_posX", 32'(posX), 32'd320);
    check_eq("right40_canRight", 32'(canRight), 32'd0);
    drive(1'b1, 3'd2);
    check_eq("right41_posX", 32'(posX), 32'd320);
    check_eq("right41_moved", 32'(moved), 32'd0);

    drive(1'b1, 3'd1);
    check_eq("left_posX", 32'(posX), 32'd312);
    check_eq("left_moved", 32'(moved), 32'd1);
    check_eq("left_canRight", 32'(canRight), 32'd1);
    drive(1'b0, 3'd1);
    check_eq("left_moved_drop", 32'(moved), 32'd0);
    drive(1'b1, 3'd5);
    drive(1'b1, 3'd0);

    for (int i = 0; i < 18; i++) drive(1'b1, 3'd3);
    check_eq("down18_posY", 32'(posY), 32'd320);
    check_eq("down18_landed", 32'(landed), 32'd1);
    check_eq("down18_canLeft", 32'(canLeft), 32'd0);
    check_eq("down18_canRight", 32'(canRight), 32'd0);
    drive(1'b1, 3'd2);
    drive(1'b1, 3'd3);
    drive(1'b1, 3'd1);
    check_eq("landed_posX", 32'(posX), 32'd312);
    check_eq("landed_posY", 32'(posY), 32'd320);

    // Asynchronous reset mid RIGHT run, held across an enabled edge
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd2);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_dominates");
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    drive(1'b1, 3'd2);
    check_eq("post_reset_posX", 32'(posX), 32'd8);
`else
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd2);
    check_eq("div_3_posX", 32'(posX), 32'd0);
    drive(1'b1, 3'd2);
    check_eq("div_4_posX", 32'(posX), 32'd8);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd2);
    drive(1'b1, 3'd3);
    check_eq("div_down_posY", 32'(posY), 32'd48);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'd2);
      drive(1'b1, 3'd2);
      check_eq("div_wait_posX", 32'(posX), 32'(8 + 8 * k));
      drive(1'b1, 3'd2);
      check_eq("div_step_posX", 32'(posX), 32'(16 + 8 * k));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
